// File: rtl/ibex_dmem_pipe.sv
// Pipelined data-memory model for the Ibex LSU data port.
// req/gnt/rvalid handshake with programmable grant latency, byte-lane merged
// stores, out-of-range error responses and a combinational contract read port.
module ibex_dmem_pipe #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned DEPTH             = 1024,
   parameter int unsigned ADDR_WIDTH        = $clog2(DEPTH),
   parameter int unsigned GNT_LAT           = 0,
   parameter bit          ZERO_UNUSED_BYTES = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sram_req,
   output logic                    sram_gnt,
   output logic                    sram_rvalid,
   output logic                    sram_err,
   input  logic                    sram_we,
   input  logic [DATA_WIDTH/8-1:0] sram_be,
   input  logic [ADDR_WIDTH-1:0]   sram_addr,
   input  logic [DATA_WIDTH-1:0]   sram_wdata,
   output logic [DATA_WIDTH-1:0]   sram_rdata,
   input  logic [31:0]             lsu_addr_ctr,
   output logic [DATA_WIDTH-1:0]   load_data_ctr
);

   localparam int unsigned NumLanes = DATA_WIDTH / 8;
   // Reload value for the wait counter; unused when GNT_LAT is 0.
   localparam logic [2:0] CntInit = (GNT_LAT > 0) ? 3'(GNT_LAT - 1) : 3'd0;

   typedef enum logic [1:0] {StIdle, StWait, StGrant} state_e;

   state_e                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic                    rvalid_q, err_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    hs;
   logic                    in_range;
   logic [DATA_WIDTH-1:0]   be_mask;
   logic [DATA_WIDTH-1:0]   mem_rd;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH-1:0]   ld_data;
   logic [ADDR_WIDTH-1:0]   ctr_idx;
   logic                    ctr_in_range;
   logic                    unused_ctr_bits;

   // Grant is a pure function of the registered state; reset kills any handshake.
   assign sram_gnt    = (state_q == StGrant);
   assign hs          = sram_gnt & sram_req & ~rst;
   assign in_range    = 32'(sram_addr) < 32'(DEPTH);
   assign sram_rvalid = rvalid_q;
   assign sram_err    = err_q;
   assign sram_rdata  = rdata_q;

   // Expand byte enables to a bit mask and form store-merge / load-mask data.
   always_comb begin
      be_mask = '0;
      for (int i = 0; i < NumLanes; i++) begin
         be_mask[i*8 +: 8] = {8{sram_be[i]}};
      end
      mem_rd  = in_range ? mem[sram_addr] : '0;
      wr_data = (sram_wdata & be_mask) | (ZERO_UNUSED_BYTES ? '0 : (mem_rd & ~be_mask));
      ld_data = mem_rd & be_mask;
   end

   // Grant-latency FSM next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StGrant: begin
            if (sram_req) begin
               if (GNT_LAT == 0) begin
                  state_d = StGrant;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (!sram_req) begin
               state_d = StIdle;
            end else if (cnt_q == 3'd0) begin
               state_d = StGrant;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response registers: one-cycle rvalid/err pulse, rdata held until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= hs;
         err_q    <= hs & ~in_range;
         if (hs && !sram_we) begin
            rdata_q <= ld_data;
         end
      end
   end

   // Array write; out-of-range stores are dropped.
   always_ff @(posedge clk) begin
      if (hs && sram_we && in_range) begin
         mem[sram_addr] <= wr_data;
      end
   end

   // Contract port sees array contents before any same-cycle write.
   assign ctr_idx         = lsu_addr_ctr[ADDR_WIDTH+1:2];
   assign ctr_in_range    = 32'(ctr_idx) < 32'(DEPTH);
   assign load_data_ctr   = ctr_in_range ? mem[ctr_idx] : '0;
   assign unused_ctr_bits = ^lsu_addr_ctr;

endmodule

// File: tb/tb_ibex_dmem_pipe.sv
// Directed bench for ibex_dmem_pipe: two GNT_LAT=0 instances (preserve / zero
// unused lanes) sharing one bus, plus a GNT_LAT=3 instance for latency and abort.
module tb_ibex_dmem_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_ab, req_c;
   logic        we;
   logic [3:0]  be;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic [31:0] ctr;

   logic        gnt_a, rvalid_a, err_a;
   logic [31:0] rdata_a, ctr_a;
   logic        gnt_b, rvalid_b, err_b;
   logic [31:0] rdata_b, ctr_b;
   logic        gnt_c, rvalid_c, err_c;
   logic [31:0] rdata_c, ctr_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ibex_dmem_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .GNT_LAT(0), .ZERO_UNUSED_BYTES(1'b0)) dut_a (
      .clk(clk), .rst(rst), .sram_req(req_ab), .sram_gnt(gnt_a), .sram_rvalid(rvalid_a),
      .sram_err(err_a), .sram_we(we), .sram_be(be), .sram_addr(addr), .sram_wdata(wdata),
      .sram_rdata(rdata_a), .lsu_addr_ctr(ctr), .load_data_ctr(ctr_a)
   );

   ibex_dmem_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .GNT_LAT(0), .ZERO_UNUSED_BYTES(1'b1)) dut_b (
      .clk(clk), .rst(rst), .sram_req(req_ab), .sram_gnt(gnt_b), .sram_rvalid(rvalid_b),
      .sram_err(err_b), .sram_we(we), .sram_be(be), .sram_addr(addr), .sram_wdata(wdata),
      .sram_rdata(rdata_b), .lsu_addr_ctr(ctr), .load_data_ctr(ctr_b)
   );

   ibex_dmem_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .GNT_LAT(3), .ZERO_UNUSED_BYTES(1'b0)) dut_c (
      .clk(clk), .rst(rst), .sram_req(req_c), .sram_gnt(gnt_c), .sram_rvalid(rvalid_c),
      .sram_err(err_c), .sram_we(we), .sram_be(be), .sram_addr(addr), .sram_wdata(wdata),
      .sram_rdata(rdata_c), .lsu_addr_ctr(ctr), .load_data_ctr(ctr_c)
   );

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rd_a;
      logic [31:0] rd_b;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [3:0] b, input logic [9:0] a,
                        input logic [31:0] d);
      we    = w;
      be    = b;
      addr  = a;
      wdata = d;
   endtask

   // Single transaction on the GNT_LAT=0 pair, starting from IDLE.
   task automatic txn_ab(input int i, input vec_t v);
      @(negedge clk);
      drive(v.we, v.be, v.addr, v.wdata);
      req_ab = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 32'(gnt_a), 32'd1);
      chk($sformatf("v%0d early rvalid", i), 32'(rvalid_a), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d rvalid", i), 32'(rvalid_a), 32'd1);
      chk($sformatf("v%0d err", i), 32'(err_a), 32'(v.err));
      chk($sformatf("v%0d rdata_a", i), rdata_a, v.rd_a);
      chk($sformatf("v%0d rdata_b", i), rdata_b, v.rd_b);
      req_ab = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d rvalid pulse", i), 32'(rvalid_a), 32'd0);
      chk($sformatf("v%0d err pulse", i), 32'(err_a), 32'd0);
      chk($sformatf("v%0d gnt idle", i), 32'(gnt_a), 32'd0);
   endtask

   // Single transaction on the GNT_LAT=3 instance: gnt exactly 4 cycles after req.
   task automatic txn_c(input string nm, input logic w, input logic [3:0] b,
                        input logic [9:0] a, input logic [31:0] d,
                        input logic e, input logic [31:0] rd);
      @(negedge clk);
      drive(w, b, a, d);
      req_c = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("%s wait gnt%0d", nm, k), 32'(gnt_c), 32'd0);
      end
      @(negedge clk);
      chk({nm, " gnt"}, 32'(gnt_c), 32'd1);
      chk({nm, " early rvalid"}, 32'(rvalid_c), 32'd0);
      @(negedge clk);
      chk({nm, " rvalid"}, 32'(rvalid_c), 32'd1);
      chk({nm, " err"}, 32'(err_c), 32'(e));
      chk({nm, " rdata"}, rdata_c, rd);
      req_c = 1'b0;
      @(negedge clk);
      chk({nm, " rvalid pulse"}, 32'(rvalid_c), 32'd0);
      chk({nm, " gnt after"}, 32'(gnt_c), 32'd0);
   endtask

   initial begin
      //          we    be    addr      wdata          err   rd_a           rd_b
      vecs[0]  = '{1'b1, 4'hF, 10'd5,    32'hDEADBEEF, 1'b0, 32'h00000000, 32'h00000000};
      vecs[1]  = '{1'b0, 4'hF, 10'd5,    32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'h5, 10'd5,    32'h11223344, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 4'hF, 10'd5,    32'h0,        1'b0, 32'hDE22BE44, 32'h00220044};
      vecs[4]  = '{1'b0, 4'h3, 10'd5,    32'h0,        1'b0, 32'h0000BE44, 32'h00000044};
      vecs[5]  = '{1'b0, 4'hF, 10'd1000, 32'h0,        1'b1, 32'h00000000, 32'h00000000};
      vecs[6]  = '{1'b1, 4'hF, 10'd999,  32'hCAFEF00D, 1'b0, 32'h00000000, 32'h00000000};
      vecs[7]  = '{1'b1, 4'hF, 10'd1001, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};
      vecs[8]  = '{1'b0, 4'hF, 10'd999,  32'h0,        1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[9]  = '{1'b1, 4'hF, 10'd3,    32'h01020304, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[10] = '{1'b1, 4'h8, 10'd3,    32'hAABBCCDD, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[11] = '{1'b0, 4'hF, 10'd3,    32'h0,        1'b0, 32'hAA020304, 32'hAA000000};
      vecs[12] = '{1'b0, 4'h6, 10'd3,    32'h0,        1'b0, 32'h00020300, 32'h00000000};
      vecs[13] = '{1'b1, 4'hF, 10'd8,    32'h0BADC0DE, 1'b0, 32'h00020300, 32'h00000000};

      rst    = 1'b1;
      req_ab = 1'b0;
      req_c  = 1'b0;
      drive(1'b0, 4'h0, 10'd0, 32'h0);
      ctr    = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset gnt_a", 32'(gnt_a), 32'd0);
      chk("reset rvalid_a", 32'(rvalid_a), 32'd0);
      chk("reset err_a", 32'(err_a), 32'd0);
      chk("reset rdata_a", rdata_a, 32'd0);
      chk("reset gnt_c", 32'(gnt_c), 32'd0);
      chk("reset rdata_c", rdata_c, 32'd0);

      for (int i = 0; i < 14; i++) begin
         txn_ab(i, vecs[i]);
      end

      // Contract port: combinational view, zero for out-of-range index.
      ctr = 32'h14;
      #1;
      chk("ctr mem5 a", ctr_a, 32'hDE22BE44);
      chk("ctr mem5 b", ctr_b, 32'h00220044);
      ctr = 32'hFA0;
      #1;
      chk("ctr oob", ctr_a, 32'h0);
      ctr = 32'hF9C;
      #1;
      chk("ctr mem999", ctr_a, 32'hCAFEF00D);

      // Back-to-back at full rate: st 7, ld 7, ld 8, st 8 with req held.
      @(negedge clk);
      drive(1'b1, 4'hF, 10'd7, 32'hA5A5A5A5);
      req_ab = 1'b1;
      @(negedge clk);
      chk("b2b gnt0", 32'(gnt_a), 32'd1);
      @(negedge clk);
      chk("b2b gnt1", 32'(gnt_a), 32'd1);
      chk("b2b rvalid0", 32'(rvalid_a), 32'd1);
      drive(1'b0, 4'hF, 10'd7, 32'h0);
      @(negedge clk);
      chk("b2b gnt2", 32'(gnt_a), 32'd1);
      chk("b2b rvalid1", 32'(rvalid_a), 32'd1);
      chk("b2b raw rdata", rdata_a, 32'hA5A5A5A5);
      drive(1'b0, 4'hF, 10'd8, 32'h0);
      @(negedge clk);
      chk("b2b gnt3", 32'(gnt_a), 32'd1);
      chk("b2b rvalid2", 32'(rvalid_a), 32'd1);
      chk("b2b rdata2", rdata_a, 32'h0BADC0DE);
      drive(1'b1, 4'hF, 10'd8, 32'h12121212);
      @(negedge clk);
      chk("b2b rvalid3", 32'(rvalid_a), 32'd1);
      chk("b2b store keeps rdata", rdata_a, 32'h0BADC0DE);
      req_ab = 1'b0;
      @(negedge clk);
      chk("b2b rvalid end", 32'(rvalid_a), 32'd0);
      chk("b2b gnt end", 32'(gnt_a), 32'd0);
      ctr = 32'h20;
      #1;
      chk("b2b ctr mem8", ctr_a, 32'h12121212);

      // GNT_LAT=3: store, load back, out-of-range load.
      txn_c("c st2", 1'b1, 4'hF, 10'd2, 32'h55AA55AA, 1'b0, 32'h0);
      txn_c("c ld2", 1'b0, 4'hF, 10'd2, 32'h0, 1'b0, 32'h55AA55AA);
      txn_c("c ld oob", 1'b0, 4'hF, 10'd1000, 32'h0, 1'b1, 32'h0);

      // GNT_LAT=3 abort: req dropped two cycles in gets no gnt and no response.
      @(negedge clk);
      drive(1'b0, 4'hF, 10'd2, 32'h0);
      req_c = 1'b1;
      @(negedge clk);
      chk("abort gnt1", 32'(gnt_c), 32'd0);
      @(negedge clk);
      chk("abort gnt2", 32'(gnt_c), 32'd0);
      req_c = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("abort quiet gnt%0d", k), 32'(gnt_c), 32'd0);
         chk($sformatf("abort quiet rvalid%0d", k), 32'(rvalid_c), 32'd0);
      end
      // Full latency again proves the FSM returned to IDLE.
      txn_c("c after abort", 1'b0, 4'hF, 10'd2, 32'h0, 1'b0, 32'h55AA55AA);

      // Reset on the handshake edge of a load: response dropped, rdata cleared.
      @(negedge clk);
      drive(1'b0, 4'hF, 10'd7, 32'h0);
      req_ab = 1'b1;
      @(negedge clk);
      chk("rst ld gnt", 32'(gnt_a), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst ld rvalid", 32'(rvalid_a), 32'd0);
      chk("rst ld rdata", rdata_a, 32'h0);
      chk("rst ld gnt off", 32'(gnt_a), 32'd0);
      rst    = 1'b0;
      req_ab = 1'b0;
      @(negedge clk);
      chk("rst ld no late rvalid", 32'(rvalid_a), 32'd0);

      // Reset on the handshake edge of a store: write dropped.
      drive(1'b1, 4'hF, 10'd7, 32'hFFFFFFFF);
      req_ab = 1'b1;
      @(negedge clk);
      chk("rst st gnt", 32'(gnt_a), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      req_ab = 1'b0;
      chk("rst st rvalid", 32'(rvalid_a), 32'd0);
      ctr = 32'h1C;
      #1;
      chk("ctr mem7 after reset", ctr_a, 32'hA5A5A5A5);

      // Memory survives reset through the normal load path too.
      vecs[0] = '{1'b0, 4'hF, 10'd7, 32'h0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
      txn_ab(100, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
